// File: rtl/alu_issue_arb.sv
// alu_issue_arb: ALU issue slot with N-way arbiter; define ALU_ISSUE_RR_EN for round-robin, else fixed priority
module alu_issue_arb #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 6,
  parameter int OP_W    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*OP_W-1:0]  req_op,
  input  logic [NUM_REQ*32-1:0]    req_a,
  input  logic [NUM_REQ*32-1:0]    req_b,
  input  logic [NUM_REQ*TAG_W-1:0] req_tag,
  output logic [NUM_REQ-1:0]       req_grant,
  output logic                     iss_valid,
  output logic [OP_W-1:0]          iss_op,
  output logic [31:0]              iss_a,
  output logic [31:0]              iss_b,
  output logic [TAG_W-1:0]         iss_tag,
  input  logic                     iss_ready,
  output logic [15:0]              busy_cnt
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [OP_W-1:0] NO_ALU = '0;
  logic              slot_free, hit, granted;
  logic [IW-1:0]     start, gidx;
  logic [IW:0]       j;
  logic              iss_valid_q, iss_valid_d;
  logic [OP_W-1:0]   iss_op_q, iss_op_d;
  logic [31:0]       iss_a_q, iss_a_d, iss_b_q, iss_b_d;
  logic [TAG_W-1:0]  iss_tag_q, iss_tag_d;
  logic [15:0]       busy_cnt_q, busy_cnt_d;
`ifdef ALU_ISSUE_RR_EN
  logic [IW-1:0]     ptr_q, ptr_d;
  assign start = ptr_q;
`else
  assign start = '0;
`endif

  assign slot_free = !iss_valid_q || iss_ready;

  // Search requesters starting at 'start'; scanning in reverse lets the first hit after start win
  always_comb begin
    hit  = 1'b0;
    gidx = '0;
    j    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = {1'b0, start} + (IW+1)'(k);
      j = (j >= (IW+1)'(NUM_REQ)) ? j - (IW+1)'(NUM_REQ) : j;
      if (req_valid[j[IW-1:0]]) begin
        hit  = 1'b1;
        gidx = j[IW-1:0];
      end
    end
    granted   = rst_n && hit && slot_free && !flush;
    req_grant = granted ? (NUM_REQ'(1) << gidx) : '0;
  end

  // Next slot state: flush kills, grant loads, acceptance without grant empties; stall counter saturates
  always_comb begin
    iss_valid_d = flush ? 1'b0 : granted ? 1'b1 : iss_ready ? 1'b0 : iss_valid_q;
    iss_op_d    = granted ? req_op[gidx*OP_W +: OP_W]    : iss_op_q;
    iss_a_d     = granted ? req_a[gidx*32 +: 32]         : iss_a_q;
    iss_b_d     = granted ? req_b[gidx*32 +: 32]         : iss_b_q;
    iss_tag_d   = granted ? req_tag[gidx*TAG_W +: TAG_W] : iss_tag_q;
    busy_cnt_d  = (iss_valid_q && !iss_ready && busy_cnt_q != 16'hFFFF) ? busy_cnt_q + 16'd1 : busy_cnt_q;
`ifdef ALU_ISSUE_RR_EN
    ptr_d       = !granted ? ptr_q : (gidx == IW'(NUM_REQ - 1)) ? '0 : gidx + IW'(1);
`endif
  end

  // Slot, payload, stall counter and pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_valid_q <= 1'b0;
      iss_op_q    <= NO_ALU;
      iss_a_q     <= '0;
      iss_b_q     <= '0;
      iss_tag_q   <= '0;
      busy_cnt_q  <= '0;
`ifdef ALU_ISSUE_RR_EN
      ptr_q       <= '0;
`endif
    end else begin
      iss_valid_q <= iss_valid_d;
      iss_op_q    <= iss_op_d;
      iss_a_q     <= iss_a_d;
      iss_b_q     <= iss_b_d;
      iss_tag_q   <= iss_tag_d;
      busy_cnt_q  <= busy_cnt_d;
`ifdef ALU_ISSUE_RR_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign iss_valid = iss_valid_q;
  assign iss_op    = iss_op_q;
  assign iss_a     = iss_a_q;
  assign iss_b     = iss_b_q;
  assign iss_tag   = iss_tag_q;
  assign busy_cnt  = busy_cnt_q;
endmodule

// File: tb/tb_alu_issue_arb.sv
// tb_alu_issue_arb: scoreboard bench for alu_issue_arb (RR when ALU_ISSUE_RR_EN is defined)
module tb_alu_issue_arb;
  localparam int NR = 4;
  localparam int TW = 6;
  localparam int OW = 4;
  localparam logic [OW-1:0] ADD_ALU = 4'd1;

  logic clk = 1'b0;
  logic rst_n, flush, iss_ready, iss_valid;
  logic [NR-1:0] req_valid, req_grant;
  logic [NR*OW-1:0] req_op;
  logic [NR*32-1:0] req_a, req_b;
  logic [NR*TW-1:0] req_tag;
  logic [OW-1:0] iss_op;
  logic [31:0] iss_a, iss_b;
  logic [TW-1:0] iss_tag;
  logic [15:0] busy_cnt;

  logic [OW-1:0] r_op [NR];
  logic [31:0]   r_a  [NR];
  logic [31:0]   r_b  [NR];
  logic [TW-1:0] r_tag[NR];

  logic [OW+64+TW-1:0] sb[$];
  logic        m_v;
  int          m_ptr;
  logic [15:0] m_busy;
  int n_checks = 0, n_errors = 0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < NR; i++) begin : g_pack
    assign req_op[i*OW +: OW]  = r_op[i];
    assign req_a[i*32 +: 32]   = r_a[i];
    assign req_b[i*32 +: 32]   = r_b[i];
    assign req_tag[i*TW +: TW] = r_tag[i];
  end

  alu_issue_arb #(.NUM_REQ(NR), .TAG_W(TW), .OP_W(OW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .req_valid(req_valid),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .req_grant(req_grant), .iss_valid(iss_valid), .iss_op(iss_op),
    .iss_a(iss_a), .iss_b(iss_b), .iss_tag(iss_tag),
    .iss_ready(iss_ready), .busy_cnt(busy_cnt)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic rand_payloads();
    for (int i = 0; i < NR; i++) begin
      r_op[i]  = OW'($urandom);
      r_a[i]   = $urandom;
      r_b[i]   = $urandom;
      r_tag[i] = TW'($urandom);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_v = 1'b0;
    m_ptr = 0;
    m_busy = '0;
  endtask

  // One cycle: compare at negedge against the model, then advance model and clock
  task automatic step(input int ei);
    int gi;
    @(negedge clk);
    gi = -1;
    if (!flush && (!m_v || iss_ready))
      for (int k = 0; k < NR; k++)
        if (gi < 0 && req_valid[(m_ptr + k) % NR]) gi = (m_ptr + k) % NR;
    check("grant", req_grant, (gi < 0) ? 0 : (1 << gi));
    if (ei >= 0) check("grant_seq", req_grant, 1 << ei);
    check("iss_valid", iss_valid, m_v);
    check("busy_cnt", busy_cnt, m_busy);
    if (m_v) begin
      if (sb.size() == 0) check("sb_empty", 1, 0);
      else begin
        check("payload", {iss_op, iss_a, iss_b, iss_tag}, sb[0]);
        if (flush || iss_ready) void'(sb.pop_front());
      end
    end
    if (gi >= 0) sb.push_back({r_op[gi], r_a[gi], r_b[gi], r_tag[gi]});
    if (m_v && !iss_ready && m_busy != 16'hFFFF) m_busy++;
    m_v = flush ? 1'b0 : (gi >= 0) ? 1'b1 : iss_ready ? 1'b0 : m_v;
`ifdef ALU_ISSUE_RR_EN
    if (gi >= 0) m_ptr = (gi + 1) % NR;
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; iss_ready = 1'b0; req_valid = '1;
    rand_payloads();
    model_reset();
    #12;
    check("rst_valid", iss_valid, 0);
    check("rst_busy", busy_cnt, 0);
    check("rst_grant", req_grant, 0);
    check("rst_payload", {iss_op, iss_a, iss_b, iss_tag}, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // all four requesting with ALU always ready
    req_valid = 4'b1111; iss_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      rand_payloads();
`ifdef ALU_ISSUE_RR_EN
      step(c % NR);
`else
      step(0);
`endif
      check("valid_from_c2", iss_valid, 1);
    end
    req_valid = '0;
    step(-1); step(-1);

    // single requester into a stalled ALU
    req_valid = 4'b0100; iss_ready = 1'b0;
    r_op[2] = ADD_ALU; r_a[2] = 32'd5; r_b[2] = 32'd7; r_tag[2] = 6'd9;
    step(-1);
    for (int c = 0; c < 3; c++) begin
      step(-1);
      check("stall_payload", {iss_op, iss_a, iss_b, iss_tag}, {ADD_ALU, 32'd5, 32'd7, 6'd9});
    end
    check("busy3", busy_cnt, 3);
    req_valid = '0; iss_ready = 1'b1;
    step(-1); step(-1);

    // back-to-back replacement
    req_valid = 4'b0001; r_tag[0] = 6'd3; iss_ready = 1'b0;
    step(-1);
    req_valid = 4'b0010; r_tag[1] = 6'd4; iss_ready = 1'b1;
    step(-1);
    check("b2b_tag", iss_tag, 4);
    check("b2b_valid", iss_valid, 1);
    req_valid = '0;
    step(-1);

    // flush kills slot and blocks grant
    req_valid = 4'b1000; iss_ready = 1'b0;
    step(-1);
    flush = 1'b1; req_valid = 4'b0011;
    step(-1);
    check("flush_valid", iss_valid, 0);
    flush = 1'b0; req_valid = 4'b1111; iss_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin rand_payloads(); step(-1); end

    // random traffic
    for (int c = 0; c < 300; c++) begin
      rand_payloads();
      req_valid = NR'($urandom);
      iss_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 15) == 0);
      step(-1);
    end
    flush = 1'b0;

    // long stall saturates the counter
    req_valid = 4'b0001; iss_ready = 1'b0;
    step(-1);
    req_valid = '0;
    repeat (70000) @(posedge clk);
    #1;
    m_busy = 16'hFFFF;
    check("busy_sat", busy_cnt, 16'hFFFF);
    check("busy_sat_valid", iss_valid, 1);
    for (int c = 0; c < 4; c++) step(-1);

    // asynchronous reset mid-stall
    req_valid = 4'b1111;
    #3 rst_n = 1'b0;
    #1;
    check("arst_valid", iss_valid, 0);
    check("arst_busy", busy_cnt, 0);
    check("arst_grant", req_grant, 0);
    model_reset();
    @(posedge clk); #2 rst_n = 1'b1;
    iss_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      rand_payloads();
`ifdef ALU_ISSUE_RR_EN
      step(c);
`else
      step(0);
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
